// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline types and constants for hazard control
package pipe_pkg;

    localparam int          REG_AW    = 5;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
    } sb_slot_t;

    typedef enum logic [1:0] {RUN, STALL, FLUSH, FREEZE} mode_t;

    function automatic logic slot_hit(sb_slot_t s, logic [REG_AW-1:0] r);
        return s.v && (s.rd == r);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - ID-stage operand info and stage-register controls
interface hazard_ctrl_if;
    import pipe_pkg::*;

    logic              valid_ID;
    logic [REG_AW-1:0] rs1_ID;
    logic [REG_AW-1:0] rs2_ID;
    logic              use_rs1_ID;
    logic              use_rs2_ID;
    logic [REG_AW-1:0] rd_ID;
    logic              wr_ID;
    logic              redirect_EX;
    logic              dmem_busy;
    logic              en_PC;
    logic              en_IFID;
    logic              NOP_IFID;
    logic              en_IDEX;
    logic              NOP_IDEX;
    logic              en_EXMEM;
    logic              en_MEMWB;

    modport master (
        output valid_ID, rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, rd_ID, wr_ID,
        output redirect_EX, dmem_busy,
        input  en_PC, en_IFID, NOP_IFID, en_IDEX, NOP_IDEX, en_EXMEM, en_MEMWB
    );

    modport slave (
        input  valid_ID, rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID, rd_ID, wr_ID,
        input  redirect_EX, dmem_busy,
        output en_PC, en_IFID, NOP_IFID, en_IDEX, NOP_IDEX, en_EXMEM, en_MEMWB
    );

endinterface

// File: rtl/hz_scoreboard.sv
// rtl/hz_scoreboard.sv - two-slot (EX, MEM) destination scoreboard with match logic
module hz_scoreboard
    import pipe_pkg::*;
(
    input  logic              clk_HZD,
    input  logic              rst_HZD,
    input  logic              hold,
    input  logic              bubble,
    input  sb_slot_t          load_slot,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic              hit_rs1,
    output logic              hit_rs2,
    output sb_slot_t          ex_slot,
    output sb_slot_t          mem_slot
);

    always_ff @(posedge clk_HZD) begin
        if (!rst_HZD) begin
            ex_slot  <= '0;
            mem_slot <= '0;
        end else if (!hold) begin
            ex_slot  <= bubble ? sb_slot_t'('0) : load_slot;
            mem_slot <= ex_slot;
        end
    end

    assign hit_rs1 = slot_hit(ex_slot, rs1) | slot_hit(mem_slot, rs1);
    assign hit_rs2 = slot_hit(ex_slot, rs2) | slot_hit(mem_slot, rs2);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/freeze decode for a pipeline without forwarding
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_HZD,
    input  logic             rst_HZD,
    hazard_ctrl_if.slave     hif,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    mode_t    mode;
    logic     hit_rs1;
    logic     hit_rs2;
    logic     hz;
    sb_slot_t load_slot;
    sb_slot_t ex_slot;
    sb_slot_t mem_slot;

    assign hz = hif.valid_ID &
                ((hif.use_rs1_ID & (hif.rs1_ID != '0) & hit_rs1) |
                 (hif.use_rs2_ID & (hif.rs2_ID != '0) & hit_rs2));

    assign load_slot.v  = hif.valid_ID & hif.wr_ID & (hif.rd_ID != '0);
    assign load_slot.rd = hif.rd_ID;

    always_comb begin
        mode = RUN;
        if (hif.dmem_busy)        mode = FREEZE;
        else if (hif.redirect_EX) mode = FLUSH;
        else if (hz)              mode = STALL;
    end

    hz_scoreboard u_sb (
        .clk_HZD   (clk_HZD),
        .rst_HZD   (rst_HZD),
        .hold      (mode == FREEZE),
        .bubble    ((mode == STALL) || (mode == FLUSH)),
        .load_slot (load_slot),
        .rs1       (hif.rs1_ID),
        .rs2       (hif.rs2_ID),
        .hit_rs1   (hit_rs1),
        .hit_rs2   (hit_rs2),
        .ex_slot   (ex_slot),
        .mem_slot  (mem_slot)
    );

    // Stage registers only see reset while enabled, so reset forces every enable high.
    always_comb begin
        hif.en_PC    = 1'b1;
        hif.en_IFID  = 1'b1;
        hif.NOP_IFID = 1'b0;
        hif.en_IDEX  = 1'b1;
        hif.NOP_IDEX = 1'b0;
        hif.en_EXMEM = 1'b1;
        hif.en_MEMWB = 1'b1;
        if (rst_HZD) begin
            case (mode)
                FREEZE: begin
                    hif.en_PC    = 1'b0;
                    hif.en_IFID  = 1'b0;
                    hif.en_IDEX  = 1'b0;
                    hif.en_EXMEM = 1'b0;
                    hif.en_MEMWB = 1'b0;
                end
                FLUSH: begin
                    hif.NOP_IFID = 1'b1;
                    hif.NOP_IDEX = 1'b1;
                end
                STALL: begin
                    hif.en_PC    = 1'b0;
                    hif.en_IFID  = 1'b0;
                    hif.NOP_IDEX = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_HZD) begin
        if (!rst_HZD) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (mode == STALL) stall_cnt <= stall_cnt + 1'b1;
            if (mode == FLUSH) flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule
